// File: rtl/fifo_sync_fwft.sv
// Synchronous first-word-fall-through FIFO with registered status flags.
// The head word is read asynchronously from the storage array, so it is valid as soon as empty drops.
module fifo_sync_fwft #(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned ADDR_WIDTH       = 10,
    parameter int unsigned PROG_FULL_THRESH = (1 << ADDR_WIDTH) - 16
) (
    input  logic                  aclk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_wren,
    output logic                  write_full,
    output logic [DATA_WIDTH-1:0] read_data,
    input  logic                  read_rden,
    output logic                  read_empty,
    output logic [ADDR_WIDTH:0]   data_count,
    output logic                  prog_full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned          Depth      = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]  ProgThresh = (ADDR_WIDTH + 1)'(PROG_FULL_THRESH);
    localparam logic [ADDR_WIDTH:0]  DepthCount = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem_q [Depth];

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic                full_q, full_d;
    logic                empty_q, empty_d;
    logic                prog_full_q, prog_full_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic                wr_accept;
    logic                rd_accept;

    // Acceptance uses only the registered flags, so a simultaneous read never frees a slot
    // for a write at full (and vice versa at empty).
    always_comb begin
        wr_accept   = write_wren & ~full_q;
        rd_accept   = read_rden & ~empty_q;
        wr_ptr_d    = wr_ptr_q + (ADDR_WIDTH + 1)'(wr_accept);
        rd_ptr_d    = rd_ptr_q + (ADDR_WIDTH + 1)'(rd_accept);
        empty_d     = (wr_ptr_d == rd_ptr_d);
        full_d      = (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]) &&
                      (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]);
        count_d     = wr_ptr_d - rd_ptr_d;
        prog_full_d = (count_d >= ProgThresh);
        overflow_d  = write_wren & full_q;
        underflow_d = read_rden & empty_q;
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            prog_full_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            prog_full_q <= prog_full_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is never reset so it can map onto RAM primitives.
    always_ff @(posedge aclk) begin
        if (wr_accept && !rst) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= write_data;
        end
    end

    assign read_data  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    assign write_full = full_q;
    assign read_empty = empty_q;
    assign data_count = count_q;
    assign prog_full  = prog_full_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

    assert property (@(posedge aclk) disable iff (rst) !(full_q && empty_q));
    assert property (@(posedge aclk) disable iff (rst) count_q <= DepthCount);
    assert property (@(posedge aclk) disable iff (rst) full_q == (count_q == DepthCount));

endmodule

// File: tb/tb_fifo_sync_fwft.sv
// Bench for fifo_sync_fwft: directed vector table, hand-written corner sequences and a
// randomized run, all checked against a queue-based model of the FIFO.
module tb_fifo_sync_fwft;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned PFT   = 12;

    logic          aclk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] write_data = '0;
    logic          write_wren = 1'b0;
    logic          write_full;
    logic [DW-1:0] read_data;
    logic          read_rden = 1'b0;
    logic          read_empty;
    logic [AW:0]   data_count;
    logic          prog_full;
    logic          overflow;
    logic          underflow;

    fifo_sync_fwft #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .PROG_FULL_THRESH(PFT)
    ) dut (
        .aclk      (aclk),
        .rst       (rst),
        .write_data(write_data),
        .write_wren(write_wren),
        .write_full(write_full),
        .read_data (read_data),
        .read_rden (read_rden),
        .read_empty(read_empty),
        .data_count(data_count),
        .prog_full (prog_full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 aclk = ~aclk;

    int checks   = 0;
    int failures = 0;

    // Reference model: contents as a queue, pulse flags from the previous edge.
    logic [DW-1:0] mq[$];
    logic          m_ov = 1'b0;
    logic          m_un = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_cmp();
        chk("model_count", 32'(data_count), 32'(mq.size()));
        chk("model_empty", 32'(read_empty), 32'(mq.size() == 0));
        chk("model_full", 32'(write_full), 32'(mq.size() == DEPTH));
        chk("model_prog_full", 32'(prog_full), 32'(mq.size() >= PFT));
        chk("model_overflow", 32'(overflow), 32'(m_ov));
        chk("model_underflow", 32'(underflow), 32'(m_un));
        if (mq.size() != 0) chk("model_head", 32'(read_data), 32'(mq[0]));
    endtask

    // One clock: drive inputs, take the edge, update the model, then compare 1 ns later.
    task automatic step(input logic r, input logic w, input logic [DW-1:0] d, input logic rd);
        bit was_full;
        bit was_empty;
        rst        = r;
        write_wren = w;
        write_data = d;
        read_rden  = rd;
        @(posedge aclk);
        if (r) begin
            mq.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
        end else begin
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            m_ov = w && was_full;
            m_un = rd && was_empty;
            if (rd && !was_empty) void'(mq.pop_front());
            if (w && !was_full) mq.push_back(d);
        end
        #1;
        model_cmp();
    endtask

    typedef struct {
        logic          r;
        logic          w;
        logic [DW-1:0] d;
        logic          rd;
        int            e_count;
        logic          e_empty;
        logic          e_un;
        logic [DW-1:0] e_data;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{r: 1'b1, w: 1'b1, d: 8'h55, rd: 1'b0, e_count: 0, e_empty: 1'b1, e_un: 1'b0, e_data: 8'h00};
        vecs[1] = '{r: 1'b0, w: 1'b1, d: 8'h11, rd: 1'b0, e_count: 1, e_empty: 1'b0, e_un: 1'b0, e_data: 8'h11};
        vecs[2] = '{r: 1'b0, w: 1'b0, d: 8'h00, rd: 1'b1, e_count: 0, e_empty: 1'b1, e_un: 1'b0, e_data: 8'h00};
        vecs[3] = '{r: 1'b0, w: 1'b0, d: 8'h00, rd: 1'b1, e_count: 0, e_empty: 1'b1, e_un: 1'b1, e_data: 8'h00};
        vecs[4] = '{r: 1'b0, w: 1'b1, d: 8'hAA, rd: 1'b1, e_count: 1, e_empty: 1'b0, e_un: 1'b1, e_data: 8'hAA};
        vecs[5] = '{r: 1'b0, w: 1'b0, d: 8'h00, rd: 1'b0, e_count: 1, e_empty: 1'b0, e_un: 1'b0, e_data: 8'hAA};
        vecs[6] = '{r: 1'b0, w: 1'b0, d: 8'h00, rd: 1'b1, e_count: 0, e_empty: 1'b1, e_un: 1'b0, e_data: 8'h00};

        // Reset first, then the vector table (fall-through, underflow, read+write at empty).
        step(1'b1, 1'b0, 8'h00, 1'b0);
        chk("reset_empty", 32'(read_empty), 32'd1);
        chk("reset_count", 32'(data_count), 32'd0);
        for (int i = 0; i < 7; i++) begin
            step(vecs[i].r, vecs[i].w, vecs[i].d, vecs[i].rd);
            chk($sformatf("vec%0d_count", i), 32'(data_count), 32'(vecs[i].e_count));
            chk($sformatf("vec%0d_empty", i), 32'(read_empty), 32'(vecs[i].e_empty));
            chk($sformatf("vec%0d_underflow", i), 32'(underflow), 32'(vecs[i].e_un));
            if (!vecs[i].e_empty) chk($sformatf("vec%0d_data", i), 32'(read_data), 32'(vecs[i].e_data));
        end

        // Fill 0..15, watching prog_full around its threshold.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'(i), 1'b0);
            if (i == 10) chk("prog_full_at_11", 32'(prog_full), 32'd0);
            if (i == 11) chk("prog_full_at_12", 32'(prog_full), 32'd1);
        end
        chk("fill_full", 32'(write_full), 32'd1);
        chk("fill_count", 32'(data_count), 32'd16);
        step(1'b0, 1'b1, 8'h99, 1'b0);
        chk("ovf_pulse", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(data_count), 32'd16);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("ovf_one_cycle", 32'(overflow), 32'd0);
        chk("ovf_head", 32'(read_data), 32'd0);

        // Read and write together at full: only the read is accepted.
        step(1'b0, 1'b1, 8'h77, 1'b1);
        chk("full_rw_ovf", 32'(overflow), 32'd1);
        chk("full_rw_count", 32'(data_count), 32'd15);
        chk("full_rw_head", 32'(read_data), 32'd1);
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("drain_%0d", i), 32'(read_data), 32'(i));
            step(1'b0, 1'b0, 8'h00, 1'b1);
            if (i == 4) chk("prog_full_drop_11", 32'(prog_full), 32'd0);
        end
        chk("drained_empty", 32'(read_empty), 32'd1);

        // Half fill, then stream 100 words with simultaneous read and write across wraps.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b1, 8'(i), 1'b1);
            chk("stream_count", 32'(data_count), 32'd8);
        end

        // Reset mid-operation with a pending write.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
        step(1'b1, 1'b1, 8'hEE, 1'b0);
        chk("rst_mid_empty", 32'(read_empty), 32'd1);
        chk("rst_mid_count", 32'(data_count), 32'd0);
        chk("rst_mid_ovf", 32'(overflow), 32'd0);
        chk("rst_mid_unf", 32'(underflow), 32'd0);
        step(1'b0, 1'b1, 8'h3C, 1'b0);
        chk("post_rst_write", 32'(read_data), 32'h3C);
        chk("post_rst_count", 32'(data_count), 32'd1);

        // Randomized traffic with phases biased towards filling and draining.
        for (int i = 0; i < 3000; i++) begin
            int wp;
            int rp;
            wp = ((i / 250) % 2 == 0) ? 75 : 30;
            rp = 100 - wp;
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 99) < wp,
                 8'($urandom),
                 $urandom_range(0, 99) < rp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
